move_input_ctrl: RTL

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

---
 rtl/move_input_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/move_input_ctrl.sv
// Button front end: two-flop sync, per-channel debounce, press detection with
// lowest-index priority, optional auto-repeat, and a small command FIFO with drop accounting.
module move_input_ctrl #(
  parameter int N_BTNS          = 5,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int QDEPTH          = 4,
  parameter int REPEAT_DELAY    = 200,
  parameter int REPEAT_PERIOD   = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTNS-1:0] btn,
  input  logic              repeat_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CODE_W-1:0] cmd_code,
  output logic [N_BTNS-1:0] btn_level,
  output logic              drop_pulse,
  output logic [7:0]        drop_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W  = $clog2(T_MAX);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [N_BTNS-1:0] r_sync1, r_sync2, r_level, r_level_d;
  logic [DB_W-1:0]   r_db_cnt [N_BTNS];

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      for (int i = 0; i < N_BTNS; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      for (int i = 0; i < N_BTNS; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign btn_level = r_level;

  logic [N_BTNS-1:0] w_press;
  logic              w_press_any;
  logic [CODE_W-1:0] w_press_code;

  assign w_press = r_level & ~r_level_d;

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_press_any  = 1'b0;
    w_press_code = '0;
    for (int i = N_BTNS - 1; i >= 0; i--) begin
      if (w_press[i]) begin
        w_press_any  = 1'b1;
        w_press_code = CODE_W'(i);
      end
    end
  end

  state_t            r_state, w_state_next;
  logic [TM_W-1:0]   r_timer, w_timer_next;
  logic [CODE_W-1:0] r_active, w_active_next;
  logic              w_active_level, w_rep_event;

  always_comb begin
    w_active_level = 1'b0;
    for (int i = 0; i < N_BTNS; i++)
      if (r_active == CODE_W'(i)) w_active_level = r_level[i];
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_active_next = r_active;
    w_rep_event   = 1'b0;
    if (w_press_any && repeat_en) begin
      w_state_next  = S_DELAY;
      w_active_next = w_press_code;
      w_timer_next  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_DELAY: begin
          if (!w_active_level || !repeat_en) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
          end else if (r_timer == TM_W'(REPEAT_DELAY - 1)) begin
            w_rep_event  = 1'b1;
            w_state_next = S_REPEAT;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer + TM_W'(1);
          end
        end
        S_REPEAT: begin
          if (!w_active_level || !repeat_en) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
          end else if (r_timer == TM_W'(REPEAT_PERIOD - 1)) begin
            w_rep_event  = 1'b1;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer + TM_W'(1);
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_active <= '0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_active <= w_active_next;
    end
  end

  // Presses outrank repeats; a suppressed repeat is simply not generated.
  logic              w_push, w_pop, w_full, w_wr_en, w_drop;
  logic [CODE_W-1:0] w_push_code, w_code_next;
  logic [CODE_W-1:0] r_mem [QDEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic [CODE_W-1:0] r_cmd_code;
  logic              r_drop_pulse;
  logic [7:0]        r_drop_count;

  assign w_push      = w_press_any | w_rep_event;
  assign w_push_code = w_press_any ? w_press_code : r_active;
  assign cmd_valid   = (r_count != '0);
  assign w_pop       = cmd_valid & cmd_ready;
  assign w_full      = (r_count == CNT_W'(QDEPTH));
  assign w_wr_en     = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_rd_ptr_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_en && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (!w_wr_en && w_pop) w_count_next = r_count - CNT_W'(1);
    // Head after the edge is the incoming entry when the queue would otherwise be empty.
    if (w_count_next == '0)
      w_code_next = '0;
    else if (r_count == '0 || (w_pop && r_count == CNT_W'(1)))
      w_code_next = w_push_code;
    else
      w_code_next = r_mem[w_rd_ptr_next];
  end

  // NOTE: queue storage is not reset; occupancy and the registered head carry all visible state.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_push_code;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cmd_code   <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr     <= w_rd_ptr_next;
      r_count      <= w_count_next;
      r_cmd_code   <= w_code_next;
      r_drop_pulse <= w_drop;
      if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign cmd_code   = r_cmd_code;
  assign drop_pulse = r_drop_pulse;
  assign drop_count = r_drop_count;

endmodule
